// File: rtl/ibuf_fifo.sv
// Multi-entry router input buffer: FIFO of {route, payload} with per-direction multicast retirement.
// Latency: a push is visible on arb_req/payload_o the cycle after acceptance, with no same-cycle bypass.
// Backpressure: ibuf_rdy drops when all DEPTH entries are occupied and comes only from registered state.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ibuf_vld/ibuf_rdy   upstream handshake; route_req + payload_i are the incoming packet
//   arb_req             remaining (not yet retired) route bits of the head entry
//   arb_gnt, obuf_rdy   per-direction grant and downstream ready; both are needed to retire a bit
//   payload_o           head entry payload, zero when empty
//   occ                 current occupancy
//   err_o               sticky flag: a packet with an all-zero route was received

`ifndef PKT_W
`define PKT_W 32
`endif

module ibuf_fifo #(
    parameter int  PYLD_W  = `PKT_W,
    parameter int  NUM_DIR = 7,
    parameter int  DEPTH   = 4,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ibuf_vld,
    output logic               ibuf_rdy,
    input  logic [NUM_DIR-1:0] route_req,
    input  logic [PYLD_W-1:0]  payload_i,
    output logic [NUM_DIR-1:0] arb_req,
    input  logic [NUM_DIR-1:0] arb_gnt,
    input  logic [NUM_DIR-1:0] obuf_rdy,
    output logic [PYLD_W-1:0]  payload_o,
    output logic [CNT_W-1:0]   occ,
    output logic               err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NUM_DIR-1:0] route_mem_q [DEPTH];
    logic [NUM_DIR-1:0] route_mem_d [DEPTH];
    logic [PYLD_W-1:0]  pyld_mem_q  [DEPTH];
    logic [PYLD_W-1:0]  pyld_mem_d  [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               not_empty;
    logic               full;
    logic               push;
    logic               push_store;
    logic               push_zero;
    logic               pop;
    logic [NUM_DIR-1:0] head_route;
    logic [NUM_DIR-1:0] clr;
    logic [NUM_DIR-1:0] remain;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        // Explicit wrap so DEPTH need not be a power of two.
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign not_empty  = (cnt_q != '0);
    assign full       = (cnt_q == CNT_W'(DEPTH));
    assign ibuf_rdy   = ~full;

    assign push       = ibuf_vld & ibuf_rdy;
    assign push_store = push & (|route_req);
    // A zero-route packet is consumed from the link but never stored.
    assign push_zero  = push & ~(|route_req);

    assign head_route = route_mem_q[rd_ptr_q];
    assign arb_req    = not_empty ? head_route : '0;
    assign payload_o  = not_empty ? pyld_mem_q[rd_ptr_q] : '0;

    // Masking with arb_req drops stray grants and makes clr zero when empty.
    assign clr        = arb_gnt & obuf_rdy & arb_req;
    assign remain     = head_route & ~clr;
    assign pop        = not_empty & ~(|remain);

    assign occ        = cnt_q;
    assign err_o      = err_q;

    always_comb begin
        route_mem_d = route_mem_q;
        pyld_mem_d  = pyld_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        err_d       = err_q | push_zero;

        // Retire granted bits of the head. When the last bit goes the entry
        // becomes all-zero, which is harmless since it is then free.
        if (not_empty) begin
            route_mem_d[rd_ptr_q] = remain;
        end

        // wr_ptr equals rd_ptr only when empty (no head update above) or full
        // (no push accepted), so the two writes never target the same entry.
        if (push_store) begin
            route_mem_d[wr_ptr_q] = route_req;
            pyld_mem_d[wr_ptr_q]  = payload_i;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push_store, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                route_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            route_mem_q <= route_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    // Payload storage carries no reset; payload_o is gated by occupancy instead.
    always_ff @(posedge clk) begin
        pyld_mem_q <= pyld_mem_d;
    end

endmodule

// File: doc/ibuf_fifo.md
Name: ibuf_fifo

Overview:
- Parametrised multi-entry router input buffer; generalises the single-entry input buffer to DEPTH entries and NUM_DIR output directions.
- Stores accepted packets in FIFO order and presents the head packet's remaining route bits as per-direction arbitration requests.
- Supports multicast: each route bit is retired independently on grant plus downstream ready; the head is popped when its last bit retires.
- Sits between the link input and the per-output arbiters of a mesh router port.

Parameters:
PYLD_W, `PKT_W, payload width in bits
NUM_DIR, 7, number of output directions (one route bit each)
DEPTH, 4, number of buffer entries (>=2, need not be a power of two)
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ibuf_vld  in  1  upstream packet valid
ibuf_rdy  out  1  buffer can accept (not full)
route_req  in  NUM_DIR  one-hot or multi-hot route of incoming packet
payload_i  in  PYLD_W  incoming packet
arb_req  out  NUM_DIR  remaining route bits of head entry
arb_gnt  in  NUM_DIR  arbiter grant per direction
obuf_rdy  in  NUM_DIR  downstream output buffer ready per direction
payload_o  out  PYLD_W  head entry payload
occ  out  CNT_W  current occupancy
err_o  out  1  sticky error: zero-route packet received

Behaviour:
- Single clock domain: clk. Reset rst is asynchronous, active-high.
- Storage: DEPTH entries of {route, payload}; wr_ptr and rd_ptr each wrap DEPTH-1 -> 0; registered count drives occ.
- Reset values: ibuf_rdy=1, arb_req=0, payload_o=0, occ=0, err_o=0, pointers=0. Payload storage is not reset.
- Asserting rst mid-operation discards all entries immediately (asynchronous).
- ibuf_rdy = (count != DEPTH), derived from registered state only; no combinational path from arb_gnt/obuf_rdy. No push is accepted on a full cycle even if a pop occurs in the same cycle.
- push = ibuf_vld & ibuf_rdy.
  - route_req != 0: entry written at wr_ptr, wr_ptr advances.
  - route_req == 0: packet consumed but not stored; err_o set next cycle and held until rst; count unchanged.
- arb_req = head route when count != 0, else 0. payload_o = head payload when count != 0, else 0.
- clr = arb_gnt & obuf_rdy & arb_req. Grant bits without a matching request are ignored. Grant without obuf_rdy clears nothing.
- Head route register updates to head_route & ~clr at each edge.
- pop = (count != 0) & ((head_route & ~clr) == 0). On pop, rd_ptr advances and the next entry's full route appears as arb_req in the following cycle.
- Multicast: bits retire in any order over any number of cycles; payload_o is stable until pop.
- Latency: a push into an empty buffer at edge N makes arb_req/payload_o valid after edge N. No same-cycle bypass.
- Count: push & pop -> unchanged; push only -> +1; pop only -> -1.
- FIFO order is preserved across pointer wrap.

Test Plan:
- Unicast: rst, push route=7'b0000001, payload=0xA5 -> next cycle arb_req=0000001, payload_o=0xA5, occ=1; then arb_gnt[0]=obuf_rdy[0]=1 -> next cycle arb_req=0, payload_o=0, occ=0.
- Multicast: push route=7'b0010011. gnt[1]=1 with obuf_rdy[1]=0 -> arb_req unchanged. gnt[0],gnt[1] with ready -> arb_req=0010000, occ=1. gnt[4] with ready -> pop, occ=0.
- Full (DEPTH=4): four pushes 0x1..0x4, no grants -> occ=4, ibuf_rdy=0; held 5th vld not accepted. One pop -> ibuf_rdy=1 next cycle; payloads emerge 0x1,0x2,0x3,0x4, then 5th.
- Concurrent: at occ=2, push and pop in the same cycle, repeated for 6 cycles -> occ stays 2, order preserved across wr_ptr/rd_ptr wrap.
- Zero route: push route=0, payload=0xFF -> err_o=1 next cycle, occ unchanged, arb_req unchanged; err_o stays 1 until rst.
- Reset mid-operation: occ=3 with a multicast head partially retired, rst pulsed -> immediately arb_req=0, ibuf_rdy=1, occ=0, err_o=0, payload_o=0; a fresh push then works as in the unicast scenario.
